// File: rtl/ldst_pkg.sv
// Shared load/store port types and helpers for the request arbiter and its ID FIFO.
package ldst_pkg;

  localparam int LDST_AW      = 32;
  localparam int LDST_DW      = 32;
  localparam int LDST_MAX_SRC = 4;

  typedef logic [1:0] ldst_src_id_t;

  typedef struct packed {
    logic               we;
    logic [LDST_AW-1:0] addr;
    logic [LDST_DW-1:0] wdata;
  } ldst_req_t;

  typedef struct packed {
    logic               err;
    logic [LDST_DW-1:0] rdata;
  } ldst_rsp_t;

  function automatic ldst_src_id_t ldst_next_src(input ldst_src_id_t id, input int n_src);
    return (int'(id) >= n_src - 1) ? ldst_src_id_t'(0) : id + ldst_src_id_t'(1);
  endfunction

endpackage

// File: rtl/ldst_id_fifo.sv
// Synchronous FIFO of source IDs in grant order; extra pointer bit distinguishes full from empty.
module ldst_id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_id,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage holds no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_id;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/ldst_arb.sv
// Round-robin arbiter sharing one load/store master port among N_SRC requesters,
// routing in-order responses back to the issuing source via an ID FIFO.
module ldst_arb
  import ldst_pkg::*;
#(
  parameter int N_SRC    = 2,
  parameter int MAX_OUTS = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  localparam int REQ_W   = 1 + AW + DW,
  localparam int RSP_W   = 1 + DW,
  localparam int CNT_W   = $clog2(MAX_OUTS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_req_vld,
  input  logic [N_SRC*REQ_W-1:0] src_req_pkt,
  output logic [N_SRC-1:0]       src_req_rdy,
  output logic [N_SRC-1:0]       src_rsp_vld,
  output logic [N_SRC*RSP_W-1:0] src_rsp_pkt,
  input  logic [N_SRC-1:0]       src_rsp_rdy,
  output logic                   gen_req_vld,
  output logic [REQ_W-1:0]       gen_req_pkt,
  input  logic                   gen_req_rdy,
  input  logic                   gen_rsp_vld,
  input  logic [RSP_W-1:0]       gen_rsp_pkt,
  output logic                   gen_rsp_rdy,
  output logic [CNT_W-1:0]       outs_cnt
);

  localparam int SID_W = $clog2(N_SRC);

  logic                    active;
  ldst_src_id_t            prio;
  ldst_src_id_t            rr_id;
  ldst_src_id_t            lock_id;
  ldst_src_id_t            winner;
  logic                    lock;
  logic                    win_vld;
  logic [REQ_W-1:0]        win_pkt;
  logic                    accept;
  logic                    rsp_fire;
  logic                    head_rdy;
  logic [SID_W-1:0]        head_id;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(MAX_OUTS):0] fifo_count;

  // Descending offsets: the requester closest at/after prio is assigned last and wins.
  always_comb begin
    rr_id = prio;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_req_vld[i] && (i == (int'(prio) + k) % N_SRC)) rr_id = ldst_src_id_t'(i);
      end
    end
  end

  assign winner = lock ? lock_id : rr_id;

  always_comb begin
    win_vld     = 1'b0;
    win_pkt     = '0;
    src_req_rdy = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ldst_src_id_t'(i) == winner) begin
        win_vld        = src_req_vld[i];
        win_pkt        = src_req_pkt[i*REQ_W +: REQ_W];
        src_req_rdy[i] = active & gen_req_rdy & ~fifo_full;
      end
    end
  end

  assign gen_req_vld = active & win_vld & ~fifo_full;
  assign gen_req_pkt = win_pkt;
  assign accept      = gen_req_vld & gen_req_rdy;

  always_comb begin
    src_rsp_vld = '0;
    head_rdy    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ldst_src_id_t'(i) == ldst_src_id_t'(head_id)) begin
        src_rsp_vld[i] = active & gen_rsp_vld & ~fifo_empty;
        head_rdy       = src_rsp_rdy[i];
      end
    end
  end

  assign src_rsp_pkt = {N_SRC{gen_rsp_pkt}};
  assign gen_rsp_rdy = active & head_rdy & ~fifo_empty;
  assign rsp_fire    = gen_rsp_vld & gen_rsp_rdy;

  // active holds every handshake output low for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      prio    <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
    end else begin
      active  <= 1'b1;
      lock    <= gen_req_vld & ~gen_req_rdy;
      lock_id <= winner;
      if (accept) prio <= ldst_next_src(winner, N_SRC);
    end
  end

  ldst_id_fifo #(
    .W     (SID_W),
    .DEPTH (MAX_OUTS)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (winner[SID_W-1:0]),
    .pop     (rsp_fire),
    .head    (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign outs_cnt = CNT_W'(fifo_count);

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) accept |-> !fifo_full);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) rsp_fire |-> !fifo_empty);
  a_no_rsp_empty: assert property (@(posedge clk) disable iff (rst) !(gen_rsp_vld && fifo_empty));
  a_req_stable:   assert property (@(posedge clk) disable iff (rst)
                                   (gen_req_vld && !gen_req_rdy) |=> $stable(gen_req_pkt));

endmodule
